// File: rtl/timctrl_pkg.sv
// Shared timing-controller definitions: supervisor state encoding and counter sizing.
// No logic; the latency and backpressure notes live with the modules.
package timctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_t;

    // Widest counter any timing block may need (parameters are capped at 2^20).
    localparam int CNT_W_MAX = 20;

    // Counters only ever hold PARAM-1, so clog2 of the largest parameter is enough.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/timctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; latency 2 cycles.
// No backpressure: samples every clock.
module timctrl_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/timctrl_pll_supervisor.sv
// PLL bring-up supervisor: pulses pll_rst, waits for a stable lock, retries, then gives up.
// Outputs registered, 1 cycle after the decision; no backpressure (restart is a 1-cycle strobe).
module timctrl_pll_supervisor
    import timctrl_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = 16,
    parameter int LOCK_TIMEOUT    = 100000,
    parameter int LOCK_STABLE     = 1024,
    parameter int MAX_RETRY       = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt,
    output logic [2:0] state
);

    localparam int CNT_W = cnt_width(RST_HOLD_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

    pll_state_t       st;
    logic [CNT_W-1:0] cnt;
    logic             locked_s;
    logic [3:0]       retry_inc;

    timctrl_sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    assign retry_inc = retry_cnt + 4'd1;
    assign state     = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= ST_RESET;
            pll_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= 4'd0;
            loss_cnt  <= 8'd0;
            cnt       <= '0;
        end else if (restart) begin
            // Restart wins over any lock/timeout event this cycle; loss history is kept.
            st        <= ST_RESET;
            pll_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= 4'd0;
            cnt       <= '0;
        end else begin
            case (st)
                ST_RESET: begin
                    if (cnt == HOLD_LAST) begin
                        st      <= ST_WAIT_LOCK;
                        pll_rst <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        // The cycle that saw lock is the first of the stable window.
                        st  <= ST_STABLE;
                        cnt <= CNT_W'(1);
                    end else if (cnt == TIMEOUT_LAST) begin
                        retry_cnt <= retry_inc;
                        pll_rst   <= 1'b1;
                        cnt       <= '0;
                        if (retry_inc == RETRY_LIMIT) begin
                            st   <= ST_FAIL;
                            fail <= 1'b1;
                        end else begin
                            st <= ST_RESET;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        st  <= ST_WAIT_LOCK;
                        cnt <= '0;
                    end else if (cnt >= STABLE_LAST) begin
                        st        <= ST_RUN;
                        ready     <= 1'b1;
                        retry_cnt <= 4'd0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        st      <= ST_RESET;
                        ready   <= 1'b0;
                        pll_rst <= 1'b1;
                        cnt     <= '0;
                        if (loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
                    end
                end
                ST_FAIL: begin
                    pll_rst <= 1'b1;
                    fail    <= 1'b1;
                end
                default: begin
                    st      <= ST_RESET;
                    pll_rst <= 1'b1;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timctrl_pll_supervisor.sv
// Directed bench for timctrl_pll_supervisor: stimulus queues expected output changes
// with their cycle; a negedge monitor pops one entry per observed output change.
module tb_timctrl_pll_supervisor;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    // {state, pll_rst, ready, fail, retry_cnt, loss_cnt}
    typedef struct {
        int          cyc;
        logic [17:0] v;
    } ev_t;

    ev_t         exp_q[$];
    int          cyc    = 0;
    int          n_vec  = 0;
    int          n_err  = 0;
    bit          done   = 1'b0;
    logic [17:0] prev_v = 18'h3FFFF;
    logic [17:0] cur_v;
    logic [7:0]  lc_exp;
    ev_t         e;

    timctrl_pll_supervisor #(
        .RST_HOLD_CYCLES (4),
        .LOCK_TIMEOUT    (20),
        .LOCK_STABLE     (8),
        .MAX_RETRY       (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int dc, input logic [2:0] st, input logic prst,
                        input logic rdy, input logic fl, input logic [3:0] rc,
                        input logic [7:0] lc);
        ev_t x;
        x.cyc = cyc + dc;
        x.v   = {st, prst, rdy, fl, rc, lc};
        exp_q.push_back(x);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        cur_v = {state, pll_rst, ready, fail, retry_cnt, loss_cnt};
        if (cyc >= 1 && cur_v !== prev_v) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_change cyc=%0d got st=%0d prst=%0b rdy=%0b fail=%0b rc=%0d lc=%0d",
                         cyc, state, pll_rst, ready, fail, retry_cnt, loss_cnt);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.v !== cur_v) begin
                    n_err++;
                    $display("FAIL event cyc=%0d got st=%0d prst=%0b rdy=%0b fail=%0b rc=%0d lc=%0d ; want cyc=%0d st=%0d prst=%0b rdy=%0b fail=%0b rc=%0d lc=%0d",
                             cyc, state, pll_rst, ready, fail, retry_cnt, loss_cnt,
                             e.cyc, e.v[17:15], e.v[14], e.v[13], e.v[12], e.v[11:8], e.v[7:0]);
                end
            end
        end
        prev_v = cur_v;
        if (done || cyc > 20000) begin
            n_vec++;
            if (!done) begin
                n_err++;
                $display("FAIL watchdog cyc=%0d stimulus did not complete", cyc);
            end else if (exp_q.size() != 0) begin
                n_err++;
                $display("FAIL missing_events got %0d pending, want 0 (next due cyc=%0d)",
                         exp_q.size(), exp_q[0].cyc);
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        restart    = 1'b0;
        push(1, 3'd0, 1, 0, 0, 4'd0, 8'd0);
        ticks(3);

        // Normal bring-up: 4-cycle pll_rst, lock 10 cycles later, ready 10 cycles after lock.
        rst = 1'b0;
        push(4, 3'd1, 0, 0, 0, 4'd0, 8'd0);
        ticks(10);
        pll_locked = 1'b1;
        push(3,  3'd2, 0, 0, 0, 4'd0, 8'd0);
        push(10, 3'd3, 0, 1, 0, 4'd0, 8'd0);
        ticks(10);

        // Restart lands in the same cycle the FSM sees lock loss: no loss counted.
        push(3,  3'd0, 1, 0, 0, 4'd0, 8'd0);
        push(7,  3'd1, 0, 0, 0, 4'd0, 8'd0);
        push(8,  3'd2, 0, 0, 0, 4'd0, 8'd0);
        push(15, 3'd3, 0, 1, 0, 4'd0, 8'd0);
        pll_locked = 1'b0;
        ticks(1);
        pll_locked = 1'b1;
        ticks(1);
        restart = 1'b1;
        ticks(1);
        restart = 1'b0;
        ticks(13);

        // 300 one-cycle lock drops in RUN; loss_cnt saturates at 255.
        for (int i = 0; i < 300; i++) begin
            lc_exp = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            push(3,  3'd0, 1, 0, 0, 4'd0, lc_exp);
            push(7,  3'd1, 0, 0, 0, 4'd0, lc_exp);
            push(8,  3'd2, 0, 0, 0, 4'd0, lc_exp);
            push(15, 3'd3, 0, 1, 0, 4'd0, lc_exp);
            pll_locked = 1'b0;
            ticks(1);
            pll_locked = 1'b1;
            ticks(15);
        end

        // One more loss, then rst at WAIT_LOCK count 10.
        pll_locked = 1'b0;
        push(3, 3'd0, 1, 0, 0, 4'd0, 8'd255);
        push(7, 3'd1, 0, 0, 0, 4'd0, 8'd255);
        ticks(17);
        rst = 1'b1;
        push(1, 3'd0, 1, 0, 0, 4'd0, 8'd0);
        ticks(2);
        rst = 1'b0;
        push(4, 3'd1, 0, 0, 0, 4'd0, 8'd0);
        ticks(4);

        // Glitch at stable count 5: back to WAIT_LOCK, full window again.
        pll_locked = 1'b1;
        push(3,  3'd2, 0, 0, 0, 4'd0, 8'd0);
        push(8,  3'd1, 0, 0, 0, 4'd0, 8'd0);
        push(9,  3'd2, 0, 0, 0, 4'd0, 8'd0);
        push(16, 3'd3, 0, 1, 0, 4'd0, 8'd0);
        ticks(5);
        pll_locked = 1'b0;
        ticks(1);
        pll_locked = 1'b1;
        ticks(10);

        // Lock lost for good: three 20-cycle timeouts then FAIL.
        pll_locked = 1'b0;
        push(3,  3'd0, 1, 0, 0, 4'd0, 8'd1);
        push(7,  3'd1, 0, 0, 0, 4'd0, 8'd1);
        push(27, 3'd0, 1, 0, 0, 4'd1, 8'd1);
        push(31, 3'd1, 0, 0, 0, 4'd1, 8'd1);
        push(51, 3'd0, 1, 0, 0, 4'd2, 8'd1);
        push(55, 3'd1, 0, 0, 0, 4'd2, 8'd1);
        push(75, 3'd4, 1, 0, 1, 4'd3, 8'd1);
        ticks(95);

        // Restart out of FAIL: fresh 4-cycle pll_rst, then lock normally.
        restart = 1'b1;
        push(1, 3'd0, 1, 0, 0, 4'd0, 8'd1);
        ticks(1);
        restart = 1'b0;
        push(4, 3'd1, 0, 0, 0, 4'd0, 8'd1);
        ticks(4);
        pll_locked = 1'b1;
        push(3,  3'd2, 0, 0, 0, 4'd0, 8'd1);
        push(10, 3'd3, 0, 1, 0, 4'd0, 8'd1);
        ticks(20);
        done = 1'b1;
    end

endmodule

// File: doc/timctrl_pll_supervisor.md
TIMCTRL_PLL_SUPERVISOR -- requirements
Module: timctrl_pll_supervisor

Interface
REQ-001 SHALL have parameter RST_HOLD_CYCLES, default 16: number of cycles pll_rst is held high per reset attempt (range 1 to 2^20).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 100000: maximum number of cycles to wait for lock after pll_rst is released (range 1 to 2^20).
REQ-003 SHALL have parameter LOCK_STABLE, default 1024: number of consecutive synchronized-locked cycles required before ready asserts (range 1 to 2^20).
REQ-004 SHALL have parameter MAX_RETRY, default 7: number of consecutive failed lock attempts before entering FAIL (range 1 to 15).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port pll_locked, input, 1 bit: PLL LOCKED, asynchronous to clk.
REQ-008 SHALL have port restart, input, 1 bit: single-cycle request to restart the sequence.
REQ-009 SHALL have port pll_rst, output, 1 bit: registered PLL reset.
REQ-010 SHALL have port ready, output, 1 bit: registered; high means the PLL is stably locked.
REQ-011 SHALL have port fail, output, 1 bit: registered; high means the retry budget is exhausted.
REQ-012 SHALL have port retry_cnt, output, 4 bits: failed attempts since the last RUN or restart.
REQ-013 SHALL have port loss_cnt, output, 8 bits: lock-loss events while in RUN, saturating at 255.
REQ-014 SHALL have port state, output, 3 bits: current FSM state encoding.

Function
REQ-015 SHALL pass pll_locked through a 2-flop synchronizer to produce locked_s, giving 2 cycles of latency.
REQ-016 SHALL implement states RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3 and FAIL=4.
REQ-017 SHALL, in RESET, drive pll_rst=1 for exactly RST_HOLD_CYCLES cycles and then go to WAIT_LOCK with pll_rst=0.
REQ-018 SHALL, in WAIT_LOCK, go to STABLE when locked_s=1.
REQ-019 SHALL, in WAIT_LOCK, treat LOCK_TIMEOUT cycles without locked_s as a timeout: retry_cnt increments, then the FSM goes to FAIL if retry_cnt equals MAX_RETRY, otherwise to RESET.
REQ-020 SHALL, in STABLE, go to RUN after LOCK_STABLE consecutive cycles of locked_s=1.
REQ-021 SHALL, in STABLE, return to WAIT_LOCK with a fresh timeout when locked_s=0; this does not count as a retry.
REQ-022 SHALL, on entry to RUN, set ready=1 in the same cycle and clear retry_cnt.
REQ-023 SHALL, in RUN, respond to locked_s=0 by setting ready=0 next cycle, incrementing loss_cnt (saturating at 255) and going to RESET.
REQ-024 SHALL hold FAIL with fail=1 and pll_rst=1 until restart or rst.
REQ-025 SHALL, on restart=1 in any state, go to RESET next cycle and clear retry_cnt, fail and ready; loss_cnt is preserved.
REQ-026 SHALL give restart priority over lock loss, timeout and lock events in the same cycle; rst has priority over everything.
REQ-027 SHALL reload the single shared cycle counter on every state transition; the counter width is the clog2 of the largest parameter.

Reset
REQ-028 SHALL, while rst=1, set state=RESET, pll_rst=1, ready=0, fail=0, retry_cnt=0, loss_cnt=0, clear the counter and clear the synchronizer flops.
REQ-029 SHALL begin the RST_HOLD_CYCLES count in the first cycle after rst falls.
REQ-030 SHALL abort any operation in progress when rst is asserted mid-operation, with no residual state.

Structure
REQ-031 SHALL place the state encoding constants and the counter-width constant in the shared package timctrl_pkg.
REQ-032 SHALL implement the synchronizer as the sub-module timctrl_sync_2ff, which is reusable across the timing-controller blocks.

Verification
(All scenarios use RST_HOLD_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRY=3.)
REQ-033 SHALL cover normal bring-up: rst released and pll_locked raised 10 cycles later -> pll_rst high exactly 4 cycles, ready rises 2+8 cycles after pll_locked rises, retry_cnt=0.
REQ-034 SHALL cover lock exhaustion: pll_locked held at 0 -> 3 timeouts of 20 cycles each, retry_cnt=3, state=FAIL, fail=1, pll_rst=1 held.
REQ-035 SHALL cover glitch during STABLE: pll_locked drops for 1 cycle at count 5 -> return to WAIT_LOCK, retry_cnt unchanged, ready delayed by a full 8-cycle stable window.
REQ-036 SHALL cover loss in RUN: pll_locked dropped 300 times -> loss_cnt saturates at 255, and each loss produces a pll_rst pulse of 4 cycles.
REQ-037 SHALL cover simultaneous events: restart in the same cycle as a lock loss in RUN -> RESET, loss_cnt not incremented; restart in FAIL -> fail=0 and a new 4-cycle pll_rst.
REQ-038 SHALL cover reset mid-WAIT_LOCK: rst asserted at count 10 -> all outputs at reset values next cycle, and the sequence restarts cleanly.
